top_syncfifo_tx: RTL

// Chip-to-FPGA result transmitter: the outbound counterpart of the SPI read-in path.

---
 rtl/top_syncfifo_tx_if.sv | 31 +++
 rtl/top_syncfifo_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/top_syncfifo_tx_if.sv
// Bundle of the ASIC push port, the packet control port and the FPGA-facing pads
// of the chip-to-FPGA result transmitter.
interface top_syncfifo_tx_if #(
  parameter int SPI_WIDTH = 32,
  parameter int TX_WIDTH  = 20
);
  logic                 wr_en;
  logic [SPI_WIDTH-1:0] wr_data;
  logic                 wr_ready;
  logic                 overflow;
  logic                 tx_start;
  logic [3:0]           tx_code;
  logic [TX_WIDTH-1:0]  tx_size;
  logic                 tx_idle;
  logic                 tx_done;
  logic                 tx_err;
  logic                 send_req;
  logic                 I_spi_cs_n;
  logic                 O_spi_valid;
  logic [SPI_WIDTH-1:0] O_spi_data;

  modport master (
    output wr_en, wr_data, tx_start, tx_code, tx_size, I_spi_cs_n,
    input  wr_ready, overflow, tx_idle, tx_done, tx_err, send_req, O_spi_valid, O_spi_data
  );

  modport slave (
    input  wr_en, wr_data, tx_start, tx_code, tx_size, I_spi_cs_n,
    output wr_ready, overflow, tx_idle, tx_done, tx_err, send_req, O_spi_valid, O_spi_data
  );
endinterface

// File: rtl/top_syncfifo_tx.sv
// Chip-to-FPGA result transmitter: a synchronous result FIFO drained as one header
// word plus tx_size payload words once the FPGA pulls I_spi_cs_n low.
module top_syncfifo_tx #(
  parameter int SPI_WIDTH       = 32,
  parameter int ADDR_WIDTH_FIFO = 5,
  parameter int TX_WIDTH        = 20
) (
  input logic               clk_chip,
  input logic               reset_chip,
  top_syncfifo_tx_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH_FIFO;
  localparam logic [ADDR_WIDTH_FIFO:0] PTR_ONE = {{ADDR_WIDTH_FIFO{1'b0}}, 1'b1};
  localparam logic [TX_WIDTH-1:0]      CNT_ONE = {{(TX_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_HEADER = 3'd3,
    S_SEND   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  logic [SPI_WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_WIDTH_FIFO:0] wr_ptr_q;
  logic [ADDR_WIDTH_FIFO:0] rd_ptr_q;
  logic [2:0]               cs_sync_q;
  state_t                   state_q;
  logic [3:0]               code_q;
  logic [TX_WIDTH-1:0]      size_q;
  logic [TX_WIDTH-1:0]      popped_q;
  logic                     overflow_q;
  logic                     send_req_q;
  logic                     valid_q;
  logic                     done_q;
  logic                     err_q;
  logic [SPI_WIDTH-1:0]     data_q;

  logic                     full_s;
  logic                     empty_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     cs_sync_s;
  logic [SPI_WIDTH-1:0]     header_s;

  // FIFO status, handshake decode and header word assembly
  always_comb begin
    full_s    = (wr_ptr_q[ADDR_WIDTH_FIFO] != rd_ptr_q[ADDR_WIDTH_FIFO]) &&
                (wr_ptr_q[ADDR_WIDTH_FIFO-1:0] == rd_ptr_q[ADDR_WIDTH_FIFO-1:0]);
    empty_s   = (wr_ptr_q == rd_ptr_q);
    push_s    = bus.wr_en && !full_s;
    cs_sync_s = cs_sync_q[2];
    // An abort cycle never pops, so unsent words stay queued for the next packet.
    pop_s     = (state_q == S_SEND) && !cs_sync_s && !empty_s && (popped_q < size_q);
    header_s  = '0;
    header_s[TX_WIDTH-1:0]      = size_q;
    header_s[SPI_WIDTH-1 -: 4]  = code_q;
  end

  // Chip-select synchronizer; the pad idles high
  always_ff @(posedge clk_chip or posedge reset_chip) begin
    if (reset_chip) begin
      cs_sync_q <= 3'b111;
    end else begin
      cs_sync_q <= {cs_sync_q[1:0], bus.I_spi_cs_n};
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk_chip or posedge reset_chip) begin
    if (reset_chip) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (bus.wr_en && full_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk_chip) begin
    if (push_s) begin
      mem_q[wr_ptr_q[ADDR_WIDTH_FIFO-1:0]] <= bus.wr_data;
    end
  end

  // Packet sequencer with registered pad and status outputs
  always_ff @(posedge clk_chip or posedge reset_chip) begin
    if (reset_chip) begin
      state_q    <= S_IDLE;
      code_q     <= 4'h0;
      size_q     <= '0;
      popped_q   <= '0;
      send_req_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.tx_start) begin
            code_q  <= bus.tx_code;
            size_q  <= bus.tx_size;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          send_req_q <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (!cs_sync_s) begin
            send_req_q <= 1'b0;
            popped_q   <= '0;
            state_q    <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (cs_sync_s) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            valid_q <= 1'b1;
            data_q  <= header_s;
            if (size_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (cs_sync_s) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (pop_s) begin
            valid_q  <= 1'b1;
            data_q   <= mem_q[rd_ptr_q[ADDR_WIDTH_FIFO-1:0]];
            popped_q <= popped_q + CNT_ONE;
          end else if (popped_q == size_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (cs_sync_s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready    = !full_s;
  assign bus.overflow    = overflow_q;
  assign bus.tx_idle     = (state_q == S_IDLE);
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;
  assign bus.send_req    = send_req_q;
  assign bus.O_spi_valid = valid_q;
  assign bus.O_spi_data  = data_q;

endmodule
